alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  8-bit registered ALU with 16 operations selected by a 4-bit opcode.
//  Produces a 16-bit result so ADD carry, full MUL product and wide shifts are never truncated.
//  Standalone datapath block used by upstream control; no handshake, one result per clock.
// PARAMETERS
//  none (widths fixed: operands 8, opcode 4, shift amount 4, result 16)
// PORTS
//  clk     in   1   single clock, all state on rising edge
//  rst     in   1   reset, synchronous, active-high
//  Out     out  16  registered result
//  Opcode  in   4   operation select (table below)
//  A       in   8   operand A, unsigned
//  B       in   8   operand B, unsigned
//  N_bit   in   4   shift/rotate amount, unsigned 0..15
// BEHAVIOUR
//  - Reset: when rst=1 at posedge clk, Out <= 16'h0000; rst has priority over everything.
//  - Latency 1: Out at edge k+1 reflects A/B/Opcode/N_bit sampled at edge k; result updates every cycle.
//  - All operands zero-extended to 16 bits; arithmetic modulo 2^16.
//  - 0 ADD : A+B (carry lands in Out[8])
//  - 1 SUB : A-B, 16-bit two's complement wrap (3-12 -> 16'hFFF7)
//  - 2 MUL : A*B, full 16-bit product
//  - 3 DIV : A/B integer quotient; B==0 -> 16'hFFFF
//  - 4 MOD : A%B; B==0 -> {8'h00,A}
//  - 5 AND, 6 OR, 7 XOR : bitwise on 8 bits, Out[15:8]=0
//  - 8 NAND, 9 NOR, 10 XNOR : bitwise on 8 bits, Out[15:8]=0
//  - 11 NOT : ~A on 8 bits, Out[15:8]=0
//  - 12 SHL : {8'h00,A} << N_bit, logical, bits beyond bit 15 discarded
//  - 13 SHR : A >> N_bit, logical, zero fill; N_bit>=8 -> 0
//  - 14 ROL : rotate 8-bit A left by N_bit mod 8, Out[15:8]=0
//  - 15 ROR : rotate 8-bit A right by N_bit mod 8, Out[15:8]=0
//  - Opcode decode is full-case; no X propagation for any 4-bit value.
//  - Reset mid-stream: result computed in that cycle is discarded, Out=0; the next non-reset edge loads a fresh result.
// STRUCTURE
//  - alu_pkg: opcode enum (OP_ADD..OP_ROR, 4-bit), width localparams, DIV0 constant 16'hFFFF.
//  - Sub-module alu_shift: combinational SHL/SHR/ROL/ROR from A, N_bit, op; remainder of ops
//    in a combinational case in alu, single 16-bit output register.
// TESTING
//  - rst=1 for 2 cycles with any inputs -> Out=0x0000; release -> first result after one edge.
//  - A=0x0C,B=0x03,N_bit=2, sweep Opcode 0..15 -> 000F,0009,0024,0004,0000,0000,000F,000F,
//    00FF,00F0,00F0,00F3,0030,0003,0030,0003 (each one cycle after apply).
//  - A=0xF6,B=0x0A: ADD -> 0x0100, SUB -> 0x00EC, MUL -> 0x099C; A=0x03,B=0x0C SUB -> 0xFFF7.
//  - B=0: A=0x0C DIV -> 0xFFFF, MOD -> 0x000C.
//  - Shift bounds: A=0x01,N_bit=15 SHL -> 0x8000; A=0x80,N_bit=9 SHR -> 0x0000;
//    A=0x81,N_bit=9 ROL -> 0x0003, ROR -> 0x00C0.
//  - Assert rst for one cycle mid opcode sweep -> Out=0 that cycle, correct result next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the registered 8-bit ALU: datapath widths,
// the 4-bit opcode enumeration and the divide-by-zero result constant.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 4;
    localparam int SHAMT_W = 4;
    localparam int RES_W   = 16;

    // Quotient reported when the divisor is zero.
    localparam logic [RES_W-1:0] DIV0 = 16'hFFFF;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NAND = 4'd8,
        OP_NOR  = 4'd9,
        OP_XNOR = 4'd10,
        OP_NOT  = 4'd11,
        OP_SHL  = 4'd12,
        OP_SHR  = 4'd13,
        OP_ROL  = 4'd14,
        OP_ROR  = 4'd15
    } op_e;

endpackage

// File: rtl/alu_shift.sv
// alu_shift
// Combinational shifter/rotator for the ALU.
// Ports:
//   a_i      [7:0]  operand A
//   n_bit_i  [3:0]  shift / rotate amount
//   op_i     op_e   operation; non-shift opcodes produce zero
//   res_o    [15:0] shift result
module alu_shift
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] n_bit_i,
    input  op_e                op_i,
    output logic [RES_W-1:0]   res_o
);

    logic [RES_W-1:0]  a_ext;
    logic [RES_W-1:0]  a_dbl;
    logic [2:0]        rot;
    logic [DATA_W-1:0] rol_b;
    logic [DATA_W-1:0] ror_b;

    assign a_ext = {8'h00, a_i};
    // Rotates use a doubled copy of A: shifting {A,A} and taking one byte
    // wraps the bits around without a separate OR of two shifted copies.
    assign a_dbl = {a_i, a_i};
    assign rot   = n_bit_i[2:0];
    assign rol_b = 8'((a_dbl << rot) >> 8);
    assign ror_b = 8'(a_dbl >> rot);

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_SHL:  res_o = a_ext << n_bit_i;
            OP_SHR:  res_o = a_ext >> n_bit_i;
            OP_ROL:  res_o = {8'h00, rol_b};
            OP_ROR:  res_o = {8'h00, ror_b};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu
// 8-bit registered ALU, 16 operations, 16-bit result, latency one clock.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset, clears Out
//   Out     [15:0] registered result
//   Opcode  [3:0]  operation select (see alu_pkg::op_e)
//   A, B    [7:0]  unsigned operands
//   N_bit   [3:0]  shift / rotate amount
module alu
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [RES_W-1:0]   Out,
    input  logic [OP_W-1:0]    Opcode,
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic [SHAMT_W-1:0] N_bit
);

    op_e              op;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] shift_res;
    logic [RES_W-1:0] out_d;
    logic [RES_W-1:0] out_q;

    assign op    = op_e'(Opcode);
    assign a_ext = {8'h00, A};
    assign b_ext = {8'h00, B};

    alu_shift u_shift (
        .a_i     (A),
        .n_bit_i (N_bit),
        .op_i    (op),
        .res_o   (shift_res)
    );

    always_comb begin
        out_d = '0;
        case (op)
            OP_ADD:  out_d = a_ext + b_ext;
            OP_SUB:  out_d = a_ext - b_ext;
            OP_MUL:  out_d = a_ext * b_ext;
            // Divisor zero is trapped explicitly so no X reaches the register.
            OP_DIV:  out_d = (B == 8'h00) ? DIV0 : {8'h00, A / B};
            OP_MOD:  out_d = (B == 8'h00) ? a_ext : {8'h00, A % B};
            OP_AND:  out_d = {8'h00, A & B};
            OP_OR:   out_d = {8'h00, A | B};
            OP_XOR:  out_d = {8'h00, A ^ B};
            OP_NAND: out_d = {8'h00, ~(A & B)};
            OP_NOR:  out_d = {8'h00, ~(A | B)};
            OP_XNOR: out_d = {8'h00, ~(A ^ B)};
            OP_NOT:  out_d = {8'h00, ~A};
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: out_d = shift_res;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign Out = out_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Scoreboard bench for alu: stimulus pushes expected results into a queue,
// an independent monitor pops one entry per clock and compares with Out.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Out;
    logic [3:0]  Opcode;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  N_bit;

    always #5 clk = ~clk;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .Out    (Out),
        .Opcode (Opcode),
        .A      (A),
        .B      (B),
        .N_bit  (N_bit)
    );

    typedef struct {
        logic [15:0] exp;
        string       tag;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic int model(input int op, input int a, input int b, input int n);
        int r;
        r = n % 8;
        case (op)
            0:  return (a + b) % 65536;
            1:  return (a - b + 65536) % 65536;
            2:  return a * b;
            3:  return (b == 0) ? 65535 : a / b;
            4:  return (b == 0) ? a : a % b;
            5:  return a & b;
            6:  return a | b;
            7:  return a ^ b;
            8:  return 255 - (a & b);
            9:  return 255 - (a | b);
            10: return 255 - (a ^ b);
            11: return 255 - a;
            12: return (a * (1 << n)) % 65536;
            13: return a / (1 << n);
            14: return ((a * (1 << r)) % 256) + (a / (1 << (8 - r))) % 256;
            default: return (a / (1 << r)) + ((a * (1 << (8 - r))) % 256);
        endcase
    endfunction

    task automatic apply(input logic r, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] n,
                         input logic [15:0] exp, input string tag);
        item_t it;
        @(negedge clk);
        rst    = r;
        Opcode = op;
        A      = a;
        B      = b;
        N_bit  = n;
        it.exp = exp;
        it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic apply_model(input logic r, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] n, input string tag);
        logic [15:0] e;
        e = r ? 16'h0000 : 16'(model(int'(op), int'(a), int'(b), int'(n)));
        apply(r, op, a, b, n, e, tag);
    endtask

    // Monitor: every rising edge produces one registered result.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_it = sb.pop_front();
            n_cmp++;
            if (Out !== mon_it.exp) begin
                n_bad++;
                $display("FAIL %s: Out=%h expected=%h", mon_it.tag, Out, mon_it.exp);
            end
        end
    end

    logic [15:0] sweep_exp [16];

    initial begin
        sweep_exp = '{16'h000F, 16'h0009, 16'h0024, 16'h0004, 16'h0000, 16'h0000,
                      16'h000F, 16'h000F, 16'h00FF, 16'h00F0, 16'h00F0, 16'h00F3,
                      16'h0030, 16'h0003, 16'h0030, 16'h0003};
        rst    = 1'b1;
        Opcode = 4'd0;
        A      = 8'h00;
        B      = 8'h00;
        N_bit  = 4'd0;

        // Reset held two cycles with arbitrary operands.
        apply(1'b1, 4'd2, 8'hFF, 8'hFF, 4'd3, 16'h0000, "reset0");
        apply(1'b1, 4'd0, 8'hAB, 8'hCD, 4'd7, 16'h0000, "reset1");

        // Opcode sweep with the documented expected table.
        for (int i = 0; i < 16; i++)
            apply(1'b0, 4'(i), 8'h0C, 8'h03, 4'd2, sweep_exp[i], $sformatf("sweep_op%0d", i));

        // Carry, wrap and full product.
        apply(1'b0, 4'd0, 8'hF6, 8'h0A, 4'd0, 16'h0100, "add_carry");
        apply(1'b0, 4'd1, 8'hF6, 8'h0A, 4'd0, 16'h00EC, "sub_pos");
        apply(1'b0, 4'd2, 8'hF6, 8'h0A, 4'd0, 16'h099C, "mul_full");
        apply(1'b0, 4'd1, 8'h03, 8'h0C, 4'd0, 16'hFFF7, "sub_wrap");
        apply(1'b0, 4'd2, 8'hFF, 8'hFF, 4'd0, 16'hFE01, "mul_max");

        // Divide by zero.
        apply(1'b0, 4'd3, 8'h0C, 8'h00, 4'd0, 16'hFFFF, "div_by0");
        apply(1'b0, 4'd4, 8'h0C, 8'h00, 4'd0, 16'h000C, "mod_by0");

        // Shift bounds.
        apply(1'b0, 4'd12, 8'h01, 8'h00, 4'd15, 16'h8000, "shl_15");
        apply(1'b0, 4'd12, 8'hFF, 8'h00, 4'd12, 16'hF000, "shl_drop");
        apply(1'b0, 4'd13, 8'h80, 8'h00, 4'd9,  16'h0000, "shr_9");
        apply(1'b0, 4'd13, 8'h80, 8'h00, 4'd7,  16'h0001, "shr_7");
        apply(1'b0, 4'd14, 8'h81, 8'h00, 4'd9,  16'h0003, "rol_9");
        apply(1'b0, 4'd15, 8'h81, 8'h00, 4'd9,  16'h00C0, "ror_9");
        apply(1'b0, 4'd14, 8'h81, 8'h00, 4'd8,  16'h0081, "rol_8");

        // Sweep again with a one-cycle reset in the middle.
        for (int i = 0; i < 16; i++) begin
            if (i == 7)
                apply(1'b1, 4'(i), 8'h0C, 8'h03, 4'd2, 16'h0000, "mid_reset");
            apply(1'b0, 4'(i), 8'h0C, 8'h03, 4'd2, sweep_exp[i], $sformatf("resweep_op%0d", i));
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            logic        r;
            logic [3:0]  op;
            logic [7:0]  a;
            logic [7:0]  b;
            logic [3:0]  n;
            r  = ($urandom_range(0, 24) == 0);
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            n  = 4'($urandom_range(0, 15));
            apply_model(r, op, a, b, n, $sformatf("rand%0d_op%0d", k, op));
        end

        // Drain with a bounded wait.
        repeat (4) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
